// File: rtl/pixel_compositor_pkg.sv
// Shared types and constants for the pixel compositor: scene codes, tile ids,
// colour-key default, brightness level width and the channel scaling helpers.
package pixel_compositor_pkg;

    // Scene codes carried on the state bus
    localparam logic [3:0] SceneStart = 4'd0;
    localparam logic [3:0] ScenePlay  = 4'd1;
    localparam logic [3:0] SceneLose  = 4'd2;
    localparam logic [3:0] SceneWin   = 4'd3;

    // Tile ids from the address generator (carried through, not decoded here)
    localparam logic [3:0] TileEmpty = 4'd0;
    localparam logic [3:0] TileWall  = 4'd1;
    localparam logic [3:0] TileChar0 = 4'd2;
    localparam logic [3:0] TileChar1 = 4'd3;

    localparam logic [11:0] KeyColorDefault = 12'h0F0;

    // Brightness level spans 0..16, so it needs one bit more than a nibble
    localparam int unsigned        LevelW    = 5;
    localparam logic [LevelW-1:0]  LevelFull = 5'd16;

    typedef enum logic [1:0] {
        FIdle,
        FBlack,
        FIn
    } fade_state_e;

    // (c * level) >> 4; level 16 is unity gain, level 0 is black
    function automatic logic [3:0] scale_chan(input logic [3:0] c,
                                              input logic [LevelW-1:0] level);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, level};
        return prod[7:4];
    endfunction

    function automatic logic [11:0] scale_rgb(input logic [11:0] rgb,
                                              input logic [LevelW-1:0] level);
        return {scale_chan(rgb[11:8], level),
                scale_chan(rgb[7:4], level),
                scale_chan(rgb[3:0], level)};
    endfunction

endpackage

// File: rtl/pixel_compositor_if.sv
// Video bus between the address-generator/BRAM front end and the compositor.
// The master drives pixel data, flags and timing; the slave returns VGA colour.
interface pixel_compositor_if;
    logic [11:0] pixel_in;
    logic        show_pixel;
    logic [3:0]  tile_id;
    logic        is_char_sync;
    logic        is_char_sync_1;
    logic        active;
    logic        vsync;
    logic [3:0]  state;
    logic [1:0]  hit;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        fade_busy;

    modport master (
        output pixel_in, show_pixel, tile_id, is_char_sync, is_char_sync_1,
               active, vsync, state, hit,
        input  vga_r, vga_g, vga_b, fade_busy
    );

    modport slave (
        input  pixel_in, show_pixel, tile_id, is_char_sync, is_char_sync_1,
               active, vsync, state, hit,
        output vga_r, vga_g, vga_b, fade_busy
    );
endinterface

// File: rtl/pixel_compositor_fade_ctrl.sv
// Scene-change fade controller: detects vsync rising edges, tracks the scene code,
// holds black for a few frames after a change and then ramps brightness back up.
module pixel_compositor_fade_ctrl
    import pixel_compositor_pkg::*;
#(
    parameter int unsigned BLACK_FRAMES = 2,
    parameter int unsigned FADE_STEP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_i,
    input  logic [3:0]        state_i,
    output logic              frame_tick_o,
    output logic [LevelW-1:0] level_o,
    output logic              fade_busy_o
);

    localparam int unsigned SumW       = LevelW + 1;
    localparam logic [7:0]  BcntReload = 8'(BLACK_FRAMES);

    logic              vsync_q;
    logic [3:0]        last_state_q;
    fade_state_e       fsm_q, fsm_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              change;
    logic [SumW-1:0]   level_sum;

    assign frame_tick_o = vsync_i & ~vsync_q;
    assign change       = (state_i != last_state_q);
    // Extra bit so a step past 16 cannot wrap before the clamp
    assign level_sum    = {1'b0, level_q} + SumW'(FADE_STEP);

    // Next-state: a scene change always restarts the black hold and beats frame_tick
    always_comb begin
        fsm_d   = fsm_q;
        bcnt_d  = bcnt_q;
        level_d = level_q;
        if (change) begin
            fsm_d   = FBlack;
            level_d = '0;
            bcnt_d  = BcntReload;
        end else begin
            unique case (fsm_q)
                FIdle: begin
                    level_d = LevelFull;
                end
                FBlack: begin
                    if (frame_tick_o) begin
                        bcnt_d = bcnt_q - 8'd1;
                        if (bcnt_q <= 8'd1) begin
                            fsm_d  = FIn;
                            bcnt_d = '0;
                        end
                    end
                end
                FIn: begin
                    if (frame_tick_o) begin
                        if (level_sum >= {1'b0, LevelFull}) begin
                            level_d = LevelFull;
                            fsm_d   = FIdle;
                        end else begin
                            level_d = level_sum[LevelW-1:0];
                        end
                    end
                end
                default: begin
                    fsm_d   = FIdle;
                    level_d = LevelFull;
                end
            endcase
        end
    end

    // State registers, including vsync edge detector and scene tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            last_state_q <= '0;
            fsm_q        <= FIdle;
            bcnt_q       <= '0;
            level_q      <= LevelFull;
        end else begin
            vsync_q      <= vsync_i;
            last_state_q <= state_i;
            fsm_q        <= fsm_d;
            bcnt_q       <= bcnt_d;
            level_q      <= level_d;
        end
    end

    assign level_o     = level_q;
    assign fade_busy_o = (fsm_q != FIdle);

endmodule

// File: rtl/pixel_compositor.sv
// Final video stage: aligns display-enable and scene code with the BRAM pixel,
// applies chroma key, background fill, hit-flash tint and fade, then registers VGA colour.
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int unsigned PIPE_LAT     = 3,
    parameter logic [11:0] KEY_COLOR    = KeyColorDefault,
    parameter logic [11:0] BG_COLOR     = 12'h113,
    parameter int unsigned BLACK_FRAMES = 2,
    parameter int unsigned FADE_STEP    = 2,
    parameter int unsigned FLASH_FRAMES = 16
) (
    input  logic                clk,
    input  logic                rst,
    pixel_compositor_if.slave   bus
);

    localparam logic [5:0] FlashLoad = 6'(FLASH_FRAMES);

    logic [PIPE_LAT-1:0] act_dly_q;
    logic [3:0]          st_dly_q [PIPE_LAT];
    logic                act_d;
    logic [3:0]          st_d;

    logic [1:0][5:0]     fl_cnt_q, fl_cnt_d;
    logic [1:0]          fl_on;

    logic                frame_tick;
    logic [LevelW-1:0]   level;

    logic                opaque;
    logic                tint;
    logic [11:0]         base;
    logic [11:0]         col_d, col_q;

    logic                unused_tile;
    assign unused_tile = ^bus.tile_id;

    pixel_compositor_fade_ctrl #(
        .BLACK_FRAMES (BLACK_FRAMES),
        .FADE_STEP    (FADE_STEP)
    ) u_fade_ctrl (
        .clk          (clk),
        .rst          (rst),
        .vsync_i      (bus.vsync),
        .state_i      (bus.state),
        .frame_tick_o (frame_tick),
        .level_o      (level),
        .fade_busy_o  (bus.fade_busy)
    );

    // Delay active/state by the BRAM pipeline depth so they line up with pixel_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_dly_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                st_dly_q[i] <= '0;
            end
        end else begin
            act_dly_q[0] <= bus.active;
            st_dly_q[0]  <= bus.state;
            for (int i = 1; i < PIPE_LAT; i++) begin
                act_dly_q[i] <= act_dly_q[i-1];
                st_dly_q[i]  <= st_dly_q[i-1];
            end
        end
    end

    assign act_d = act_dly_q[PIPE_LAT-1];
    assign st_d  = st_dly_q[PIPE_LAT-1];

    // Flash counters: a hit reloads (even mid-flash and over a coincident frame tick)
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            fl_cnt_d[k] = fl_cnt_q[k];
            if (bus.hit[k]) begin
                fl_cnt_d[k] = FlashLoad;
            end else if (frame_tick && (fl_cnt_q[k] != '0)) begin
                fl_cnt_d[k] = fl_cnt_q[k] - 6'd1;
            end
            fl_on[k] = (fl_cnt_q[k] != '0) && fl_cnt_q[k][0];
        end
    end

    // Flash counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_cnt_q <= '0;
        end else begin
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // Colour select, tint and fade; non-PLAY scenes show the raw full-screen image
    always_comb begin
        opaque = bus.show_pixel && (bus.pixel_in != KEY_COLOR);
        // When a pixel claims both characters, character 0 decides the tint
        tint   = bus.is_char_sync ? fl_on[0] : (bus.is_char_sync_1 && fl_on[1]);
        base   = '0;
        if (!act_d) begin
            base = '0;
        end else if (st_d != ScenePlay) begin
            base = bus.pixel_in;
        end else if (!opaque) begin
            base = BG_COLOR;
        end else if (tint) begin
            base = {4'hF, 1'b0, bus.pixel_in[7:5], 1'b0, bus.pixel_in[3:1]};
        end else begin
            base = bus.pixel_in;
        end
        col_d = scale_rgb(base, level);
    end

    // Output colour register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign bus.vga_r = col_q[11:8];
    assign bus.vga_g = col_q[7:4];
    assign bus.vga_b = col_q[3:0];

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: table of steady-state colour vectors
// checked through a latency scoreboard, plus directed fade/flash/reset sequences.
module tb_pixel_compositor;
    import pixel_compositor_pkg::*;

    logic clk = 1'b0;
    logic rst;

    pixel_compositor_if bus ();

    pixel_compositor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        string       name;
        logic        act;
        logic        show;
        logic [11:0] pix;
        logic        c0;
        logic        c1;
        logic [11:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   lvl;
    int   cnt;
    logic [3:0]  ch;
    logic [11:0] want;

    function automatic logic [11:0] rgb_out();
        return {bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    task automatic check12(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got rgb %03h, want %03h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and retire any due scoreboard entries
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check12(e.name, rgb_out(), e.rgb);
        end
    endtask

    task automatic expect_at(input string name, input logic [11:0] rgb, input int lat);
        exp_t e;
        e.due  = cyc + lat;
        e.name = name;
        e.rgb  = rgb;
        sb.push_back(e);
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        tick();
    endtask

    task automatic wait_fade(input string name, input int exp_frames);
        int n;
        n = 0;
        while (bus.fade_busy && n < 30) begin
            frame();
            n++;
        end
        check_int(name, n, exp_frames);
    endtask

    task automatic set_pix(input logic act, input logic show, input logic [11:0] pix,
                           input logic c0, input logic c1);
        bus.active         = act;
        bus.show_pixel     = show;
        bus.pixel_in       = pix;
        bus.is_char_sync   = c0;
        bus.is_char_sync_1 = c1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"v_abc",           1'b1, 1'b1, 12'hABC, 1'b0, 1'b0, 12'hABC};
        vecs[1] = '{"v_inactive",      1'b0, 1'b1, 12'hABC, 1'b0, 1'b0, 12'h000};
        vecs[2] = '{"v_noshow_bg",     1'b1, 1'b0, 12'hABC, 1'b0, 1'b0, 12'h113};
        vecs[3] = '{"v_key_bg",        1'b1, 1'b1, 12'h0F0, 1'b0, 1'b0, 12'h113};
        vecs[4] = '{"v_key_char0_bg",  1'b1, 1'b1, 12'h0F0, 1'b1, 1'b0, 12'h113};
        vecs[5] = '{"v_near_key",      1'b1, 1'b1, 12'h0F1, 1'b0, 1'b0, 12'h0F1};
        vecs[6] = '{"v_char0_noflash", 1'b1, 1'b1, 12'h8CE, 1'b1, 1'b0, 12'h8CE};
        vecs[7] = '{"v_black_opaque",  1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 12'h000};
        vecs[8] = '{"v_inactive_key",  1'b0, 1'b0, 12'h0F0, 1'b0, 1'b0, 12'h000};
        vecs[9] = '{"v_white_char1",   1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1, 12'hFFF};

        // Reset
        rst         = 1'b1;
        bus.vsync   = 1'b0;
        bus.state   = SceneStart;
        bus.hit     = 2'b00;
        bus.tile_id = TileEmpty;
        set_pix(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        repeat (3) tick();
        check12("reset_rgb", rgb_out(), 12'h000);
        check1("reset_busy", bus.fade_busy, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        check1("release_state0_no_fade", bus.fade_busy, 1'b0);

        // Enter PLAY: fade, then latency of active
        bus.state   = ScenePlay;
        bus.tile_id = TileChar0;
        set_pix(1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        tick();
        check1("play_change_busy", bus.fade_busy, 1'b1);
        wait_fade("play_fade_frames", 10);
        repeat (4) tick();
        check12("play_abc", rgb_out(), 12'hABC);
        bus.active = 1'b0;
        expect_at("act_off", 12'h000, 4);
        repeat (5) tick();
        bus.active = 1'b1;
        expect_at("lat_before_4", 12'h000, 3);
        expect_at("lat_at_4", 12'hABC, 4);
        repeat (5) tick();

        // Steady-state colour select table
        for (int i = 0; i < 10; i++) begin
            set_pix(vecs[i].act, vecs[i].show, vecs[i].pix, vecs[i].c0, vecs[i].c1);
            expect_at(vecs[i].name, vecs[i].exp, 4);
            repeat (5) tick();
        end

        // START scene: raw image, key colour shown, no flash tint
        bus.state = SceneStart;
        set_pix(1'b1, 1'b1, 12'h0F0, 1'b1, 1'b0);
        tick();
        wait_fade("start_fade_frames", 10);
        repeat (4) tick();
        check12("start_key_shown", rgb_out(), 12'h0F0);
        set_pix(1'b1, 1'b0, 12'h123, 1'b0, 1'b0);
        expect_at("start_noshow", 12'h123, 4);
        repeat (5) tick();
        bus.hit = 2'b01;
        tick();
        bus.hit = 2'b00;
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b1, 1'b0);
        frame();
        repeat (4) tick();
        check12("start_no_flash", rgb_out(), 12'h8CE);

        // Hit flash on character 0 in PLAY
        bus.state = ScenePlay;
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b0, 1'b0);
        tick();
        wait_fade("play2_fade_frames", 10);
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b1, 1'b0);
        bus.hit = 2'b01;
        tick();
        bus.hit = 2'b00;
        repeat (4) tick();
        check12("flash_cnt16", rgb_out(), 12'h8CE);
        for (int f = 1; f <= 17; f++) begin
            frame();
            cnt  = (f >= 16) ? 0 : 16 - f;
            want = (cnt % 2 == 1) ? 12'hF67 : 12'h8CE;
            check12($sformatf("flash_frame%0d", f), rgb_out(), want);
            if (f == 1) begin
                set_pix(1'b1, 1'b1, 12'h8CE, 1'b0, 1'b1);
                repeat (4) tick();
                check12("flash_char1_untouched", rgb_out(), 12'h8CE);
                set_pix(1'b1, 1'b1, 12'h8CE, 1'b1, 1'b0);
                repeat (4) tick();
            end
        end
        bus.hit = 2'b10;
        tick();
        bus.hit = 2'b00;
        frame();
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b0, 1'b1);
        repeat (3) tick();
        check12("flash_char1", rgb_out(), 12'hF67);
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b1, 1'b1);
        repeat (3) tick();
        check12("flash_both_char0_governs", rgb_out(), 12'h8CE);
        set_pix(1'b1, 1'b1, 12'h8CE, 1'b1, 1'b0);
        bus.hit = 2'b01;
        tick();
        bus.hit = 2'b00;
        frame();
        frame();
        check12("flash_cnt14", rgb_out(), 12'h8CE);
        bus.hit   = 2'b01;
        bus.vsync = 1'b1;
        tick();
        bus.hit   = 2'b00;
        bus.vsync = 1'b0;
        tick();
        check12("flash_hit_tick_load", rgb_out(), 12'h8CE);
        frame();
        check12("flash_after_load", rgb_out(), 12'hF67);

        // Scene change PLAY -> LOSE: full fade profile on white
        set_pix(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        repeat (5) tick();
        bus.state = SceneLose;
        tick();
        check1("lose_busy", bus.fade_busy, 1'b1);
        repeat (4) tick();
        check12("lose_black0", rgb_out(), 12'h000);
        for (int f = 1; f <= 10; f++) begin
            frame();
            lvl = (f <= 2) ? 0 : 2 * (f - 2);
            ch  = 4'((15 * lvl) / 16);
            check12($sformatf("lose_fade_f%0d", f), rgb_out(), {ch, ch, ch});
            check1($sformatf("lose_busy_f%0d", f), bus.fade_busy, (f < 10));
        end

        // Change during fade-in at level 8, coincident with a frame tick
        bus.state = SceneWin;
        tick();
        repeat (6) frame();
        repeat (3) tick();
        check12("win_level8", rgb_out(), 12'h777);
        bus.state = SceneLose;
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        tick();
        check1("restart_busy", bus.fade_busy, 1'b1);
        check12("restart_level0", rgb_out(), 12'h000);
        frame();
        check12("restart_black1", rgb_out(), 12'h000);
        frame();
        check12("restart_black2", rgb_out(), 12'h000);
        frame();
        check12("restart_in1", rgb_out(), 12'h111);
        wait_fade("restart_rest_frames", 7);

        // Asynchronous reset mid-fade and mid-flash
        bus.state = ScenePlay;
        set_pix(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0);
        bus.hit = 2'b01;
        tick();
        bus.hit = 2'b00;
        repeat (4) frame();
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check12("async_rst_rgb", rgb_out(), 12'h000);
        check1("async_rst_busy", bus.fade_busy, 1'b0);
        bus.state = SceneStart;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check1("post_rst_no_fade", bus.fade_busy, 1'b0);
        check12("post_rst_level16", rgb_out(), 12'hFFF);
        rst = 1'b1;
        bus.state = ScenePlay;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check1("release_play_fades", bus.fade_busy, 1'b1);

        repeat (6) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
